// File: rtl/sprite_dispatch_scheduler_if.sv
// rtl/sprite_dispatch_scheduler_if.sv - draw-queue head and renderer-lane signal bundle
interface sprite_dispatch_scheduler_if #(
  parameter int SPRITE_NUM = 32
);
  localparam int SEL_W = $clog2(SPRITE_NUM);

  logic               q_is_empty;
  logic [7:0]         q_sprite_id;
  logic [15:0]        q_sprite_x;
  logic [15:0]        q_sprite_y;
  logic [7:0]         q_sprite_scale;
  logic               q_dequeue;
  logic [1:0]         lane_valid;
  logic [1:0]         lane_ready;
  logic [1:0]         lane_idle;
  logic [2*SEL_W-1:0] lane_select;
  logic [31:0]        lane_x;
  logic [31:0]        lane_y;
  logic [15:0]        lane_scale;

  modport master (
    input  q_is_empty, q_sprite_id, q_sprite_x, q_sprite_y, q_sprite_scale,
    input  lane_ready, lane_idle,
    output q_dequeue, lane_valid, lane_select, lane_x, lane_y, lane_scale
  );

  modport slave (
    output q_is_empty, q_sprite_id, q_sprite_x, q_sprite_y, q_sprite_scale,
    output lane_ready, lane_idle,
    input  q_dequeue, lane_valid, lane_select, lane_x, lane_y, lane_scale
  );
endinterface

// File: rtl/sprite_dispatch_scheduler.sv
// rtl/sprite_dispatch_scheduler.sv - per-frame draw-queue to two-lane round-robin dispatcher
// Optional per-frame counters enabled by SPRITE_SCHED_STATS_EN.
module sprite_dispatch_scheduler #(
  parameter int SPRITE_NUM = 32
) (
  input  logic clock,
  input  logic reset_n,
  input  logic frame_start,
  input  logic frame_end,
  sprite_dispatch_scheduler_if.master bus,
  output logic frame_done,
  output logic frame_overrun,
  output logic busy
`ifdef SPRITE_SCHED_STATS_EN
  ,
  output logic [15:0] stat_dispatched,
  output logic [15:0] stat_dropped
`endif
);
  localparam int SEL_W = $clog2(SPRITE_NUM);
  localparam logic [8:0] ID_LIMIT = 9'(SPRITE_NUM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_FLUSH} state_t;

  state_t state, state_next;

  logic             rr;
  logic [1:0]       lane_valid_r;
  logic [SEL_W-1:0] sel_q   [2];
  logic [15:0]      x_q     [2];
  logic [15:0]      y_q     [2];
  logic [7:0]       scale_q [2];
  logic             dequeue_r, done_r, overrun_r;

  logic       head_ok, head_bad;
  logic [1:0] lane_free;
  logic       pop, load, load_lane, start_hit, end_hit, done_set;

  assign head_ok   = !bus.q_is_empty;
  assign head_bad  = ({1'b0, bus.q_sprite_id} >= ID_LIMIT) || (bus.q_sprite_scale == 8'd0);
  assign lane_free = ~lane_valid_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    load_lane  = rr;
    start_hit  = 1'b0;
    end_hit    = 1'b0;
    done_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_next = S_RUN;
          start_hit  = 1'b1;
        end
      end
      S_RUN: begin
        if (frame_end) begin
          state_next = S_FLUSH;
          end_hit    = 1'b1;
        end else if (head_ok && head_bad) begin
          pop        = 1'b1;
          state_next = S_SETTLE;
        end else if (head_ok && (lane_free != 2'b00)) begin
          pop        = 1'b1;
          load       = 1'b1;
          load_lane  = lane_free[rr] ? rr : ~rr;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // The queue head is re-sampled only after the pop has propagated.
        if (frame_end) begin
          state_next = S_FLUSH;
          end_hit    = 1'b1;
        end else begin
          state_next = S_RUN;
        end
      end
      S_FLUSH: begin
        if ((lane_valid_r == 2'b00) && (bus.lane_idle == 2'b11)) begin
          done_set   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr           <= 1'b0;
      lane_valid_r <= 2'b00;
      dequeue_r    <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        sel_q[i]   <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        scale_q[i] <= '0;
      end
    end else begin
      dequeue_r <= pop;
      done_r    <= done_set;
      if (start_hit)    overrun_r <= 1'b0;
      else if (end_hit) overrun_r <= !bus.q_is_empty;
      for (int i = 0; i < 2; i++) begin
        if (lane_valid_r[i] && bus.lane_ready[i]) lane_valid_r[i] <= 1'b0;
      end
      // A load only targets a lane that was free, so it never races the clear above.
      if (load) begin
        lane_valid_r[load_lane] <= 1'b1;
        sel_q[load_lane]        <= bus.q_sprite_id[SEL_W-1:0];
        x_q[load_lane]          <= bus.q_sprite_x;
        y_q[load_lane]          <= bus.q_sprite_y;
        scale_q[load_lane]      <= bus.q_sprite_scale;
        rr                      <= ~load_lane;
      end
    end
  end

`ifdef SPRITE_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_dispatched <= 16'd0;
      stat_dropped    <= 16'd0;
    end else if (start_hit) begin
      stat_dispatched <= 16'd0;
      stat_dropped    <= 16'd0;
    end else begin
      if (load && (stat_dispatched != 16'hFFFF))
        stat_dispatched <= stat_dispatched + 16'd1;
      if (pop && !load && (stat_dropped != 16'hFFFF))
        stat_dropped <= stat_dropped + 16'd1;
    end
  end
`endif

  assign bus.q_dequeue   = dequeue_r;
  assign bus.lane_valid  = lane_valid_r;
  assign bus.lane_select = {sel_q[1], sel_q[0]};
  assign bus.lane_x      = {x_q[1], x_q[0]};
  assign bus.lane_y      = {y_q[1], y_q[0]};
  assign bus.lane_scale  = {scale_q[1], scale_q[0]};
  assign frame_done      = done_r;
  assign frame_overrun   = overrun_r;
  assign busy            = (state != S_IDLE);
endmodule

// File: tb/tb_sprite_dispatch_scheduler.sv
// tb/tb_sprite_dispatch_scheduler.sv - directed and randomized checks of sprite_dispatch_scheduler
`timescale 1ns/1ps
module tb_sprite_dispatch_scheduler;
  localparam int SPRITE_NUM = 32;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } entry_t;

  typedef struct packed {
    logic        lane;
    logic [4:0]  sel;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } load_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic frame_end = 1'b0;
  logic frame_done, frame_overrun, busy;
`ifdef SPRITE_SCHED_STATS_EN
  logic [15:0] stat_dispatched, stat_dropped;
`endif

  sprite_dispatch_scheduler_if #(.SPRITE_NUM(SPRITE_NUM)) bus ();

  sprite_dispatch_scheduler #(.SPRITE_NUM(SPRITE_NUM)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .bus          (bus),
    .frame_done   (frame_done),
    .frame_overrun(frame_overrun),
    .busy         (busy)
`ifdef SPRITE_SCHED_STATS_EN
    ,
    .stat_dispatched(stat_dispatched),
    .stat_dropped   (stat_dropped)
`endif
  );

  always #5 clock = ~clock;

  entry_t     q[$];
  entry_t     popped[$];
  load_t      loads[$];
  load_t      cur[2];
  int         n_checks = 0;
  int         n_fail = 0;
  int         pop_count = 0;
  logic [1:0] prev_valid = 2'b00;
  logic [1:0] ready_dir = 2'b11;
  logic       rand_ready = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue model and lane monitor: pops on q_dequeue, logs every lane load.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_valid = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        load_t l;
        l.lane  = i[0];
        l.sel   = bus.lane_select[i*5 +: 5];
        l.x     = bus.lane_x[i*16 +: 16];
        l.y     = bus.lane_y[i*16 +: 16];
        l.scale = bus.lane_scale[i*8 +: 8];
        if (bus.lane_valid[i] && !prev_valid[i]) begin
          loads.push_back(l);
          cur[i] = l;
        end else if (bus.lane_valid[i]) begin
          check("payload_stable", 128'(l), 128'(cur[i]));
        end
      end
      prev_valid = bus.lane_valid;
      if (bus.q_dequeue) begin
        pop_count++;
        if (q.size() > 0) popped.push_back(q.pop_front());
      end
    end
    bus.q_is_empty = (q.size() == 0);
    if (q.size() > 0) begin
      bus.q_sprite_id    = q[0].id;
      bus.q_sprite_x     = q[0].x;
      bus.q_sprite_y     = q[0].y;
      bus.q_sprite_scale = q[0].scale;
    end else begin
      bus.q_sprite_id    = 8'd0;
      bus.q_sprite_x     = 16'd0;
      bus.q_sprite_y     = 16'd0;
      bus.q_sprite_scale = 8'd0;
    end
    bus.lane_ready = rand_ready ? 2'($urandom_range(0, 3)) : ready_dir;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_log();
    loads.delete();
    popped.delete();
    pop_count = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic push_entry(input logic [7:0] id, input logic [7:0] scale);
    entry_t e;
    e.id = id;
    e.x = 16'($urandom);
    e.y = 16'($urandom);
    e.scale = scale;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!frame_done && k < 100) begin
      tick(1);
      k++;
    end
    check(tag, 128'(frame_done), 128'(1));
    tick(1);
  endtask

  task automatic end_frame(input string tag);
    ready_dir = 2'b11;
    bus.lane_idle = 2'b11;
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    logic [7:0] mask;
    bus.lane_idle = 2'b11;
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mask;
    load_t      exp_q[$];
    int         snap;
    int         k;

    // Reset state
    apply_reset();
    check("reset_ctrl", 128'({bus.lane_valid, bus.q_dequeue, frame_done, frame_overrun, busy}), 128'(0));
    check("reset_payload", 128'({bus.lane_select, bus.lane_x, bus.lane_y, bus.lane_scale}), 128'(0));
`ifdef SPRITE_SCHED_STATS_EN
    check("reset_stats", 128'({stat_dispatched, stat_dropped}), 128'(0));
`endif

    // Three valid entries, lanes always ready: pop cadence and round-robin
    ready_dir = 2'b11;
    clear_log();
    for (int i = 1; i <= 3; i++) push_entry(8'(i), 8'(i));
    tick(1);
    pulse_start();
    check("t2_busy", 128'(busy), 128'(1));
    for (int c = 0; c < 8; c++) begin
      mask[c] = bus.q_dequeue;
      tick(1);
    end
    check("t2_pop_cycles", 128'(mask), 128'(8'b0010_1010));
    check("t2_loads", 128'(loads.size()), 128'(3));
    for (int i = 0; i < loads.size() && i < 3; i++)
      check("t2_lane_sel", 128'({loads[i].lane, loads[i].sel}), 128'({1'(i % 2), 5'(i + 1)}));
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
    check("t2_flush_c0", 128'({frame_done, busy}), 128'(2'b01));
    tick(1);
    check("t2_done", 128'({frame_done, frame_overrun, busy}), 128'(3'b100));
    tick(1);
    check("t2_done_once", 128'(frame_done), 128'(0));

    // Invalid entries dropped without dispatch
    apply_reset();
    clear_log();
    push_entry(8'd40, 8'd1);
    push_entry(8'd5, 8'd0);
    push_entry(8'd6, 8'd2);
    tick(1);
    pulse_start();
    tick(10);
    check("t3_pops", 128'(pop_count), 128'(3));
    check("t3_loads", 128'(loads.size()), 128'(1));
    if (loads.size() > 0)
      check("t3_lane0_sel6", 128'({loads[0].lane, loads[0].sel}), 128'({1'b0, 5'd6}));
`ifdef SPRITE_SCHED_STATS_EN
    check("t3_stats", 128'({stat_dispatched, stat_dropped}), 128'({16'd1, 16'd2}));
`endif
    end_frame("t3_done");

    // Backpressure: lanes never ready
    apply_reset();
    clear_log();
    ready_dir = 2'b00;
    for (int i = 0; i < 4; i++) push_entry(8'(10 + i), 8'd3);
    tick(1);
    pulse_start();
    tick(12);
    check("t4_pops", 128'(pop_count), 128'(2));
    check("t4_valid", 128'(bus.lane_valid), 128'(2'b11));
    check("t4_sel", 128'(bus.lane_select), 128'({5'd11, 5'd10}));
    if (popped.size() >= 2)
      check("t4_x", 128'(bus.lane_x), 128'({popped[1].x, popped[0].x}));
    ready_dir = 2'b10;
    tick(8);
    check("t4_pops_after", 128'(pop_count), 128'(4));
    check("t4_loads_after", 128'(loads.size()), 128'(4));
    if (loads.size() >= 3)
      check("t4_third_lane1", 128'({loads[2].lane, loads[2].sel}), 128'({1'b1, 5'd12}));
    check("t4_lane0_held", 128'(bus.lane_valid[0]), 128'(1));
    end_frame("t4_done");

    // frame_end with a poppable head; frame_start ignored in FLUSH
    apply_reset();
    clear_log();
    bus.lane_idle = 2'b00;
    push_entry(8'd7, 8'd1);
    tick(1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
    check("t5_no_pop", 128'({bus.q_dequeue, frame_overrun, busy}), 128'(3'b011));
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(2);
    check("t5_start_ignored", 128'({frame_done, frame_overrun, busy, 8'(pop_count)}), 128'({3'b011, 8'd0}));
    bus.lane_idle = 2'b11;
    wait_done("t5_done");
    check("t5_overrun_held", 128'(frame_overrun), 128'(1));
    pulse_start();
    check("t5_overrun_clr", 128'(frame_overrun), 128'(0));
    tick(3);
    check("t5_popped", 128'({8'(pop_count), 8'(loads.size())}), 128'({8'd1, 8'd1}));
    if (loads.size() > 0) check("t5_sel", 128'(loads[0].sel), 128'(5'd7));
    end_frame("t5_done2");

    // Async reset mid-FLUSH with a pending lane
    apply_reset();
    clear_log();
    ready_dir = 2'b00;
    push_entry(8'd9, 8'd1);
    tick(1);
    pulse_start();
    tick(2);
    check("t6_valid01", 128'(bus.lane_valid), 128'(2'b01));
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
    check("t6_flush_busy", 128'(busy), 128'(1));
    #2 reset_n = 1'b0;
    #1 check("t6_async_ctrl", 128'({bus.lane_valid, bus.q_dequeue, frame_done, frame_overrun, busy}), 128'(0));
    check("t6_async_payload", 128'({bus.lane_select, bus.lane_x, bus.lane_y, bus.lane_scale}), 128'(0));
    tick(1);
    reset_n = 1'b1;
    ready_dir = 2'b11;
    push_entry(8'd4, 8'd1);
    push_entry(8'd8, 8'd1);
    tick(1);
    clear_log();
    pulse_start();
    tick(6);
    check("t6_loads", 128'(loads.size()), 128'(2));
    if (loads.size() >= 2)
      check("t6_rr_restart", 128'({loads[0].lane, loads[0].sel, loads[1].lane, loads[1].sel}),
            128'({1'b0, 5'd4, 1'b1, 5'd8}));
    end_frame("t6_done");

    // Randomized frames against the filter model
    for (int f = 0; f < 4; f++) begin
      clear_log();
      for (int i = 0; i < int'($urandom_range(4, 10)); i++)
        push_entry(8'($urandom_range(0, 47)), 8'($urandom_range(0, 3)));
      snap = q.size();
      tick(1);
      rand_ready = 1'b1;
      pulse_start();
      if (f % 2 == 0) begin
        k = 0;
        while ((q.size() != 0 || bus.lane_valid != 2'b00) && k < 300) begin
          tick(1);
          k++;
        end
        check("rnd_drained", 128'(q.size()), 128'(0));
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
      end else begin
        tick(int'($urandom_range(2, 8)));
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
      end
      check("rnd_overrun", 128'(frame_overrun), 128'(q.size() != 0));
      rand_ready = 1'b0;
      ready_dir = 2'b11;
      wait_done("rnd_done");
      if (f % 2 == 0) check("rnd_all_popped", 128'(popped.size()), 128'(snap));
      exp_q.delete();
      foreach (popped[i]) begin
        if (popped[i].id < 8'(SPRITE_NUM) && popped[i].scale != 8'd0) begin
          load_t e;
          e.lane = 1'b0;
          e.sel = popped[i].id[4:0];
          e.x = popped[i].x;
          e.y = popped[i].y;
          e.scale = popped[i].scale;
          exp_q.push_back(e);
        end
      end
      check("rnd_load_count", 128'(loads.size()), 128'(exp_q.size()));
      for (int i = 0; i < loads.size() && i < exp_q.size(); i++)
        check("rnd_payload", 128'({loads[i].sel, loads[i].x, loads[i].y, loads[i].scale}),
              128'({exp_q[i].sel, exp_q[i].x, exp_q[i].y, exp_q[i].scale}));
`ifdef SPRITE_SCHED_STATS_EN
      check("rnd_stats", 128'({stat_dispatched, stat_dropped}),
            128'({16'(exp_q.size()), 16'(popped.size() - exp_q.size())}));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_dispatch_scheduler.md
Name: sprite_dispatch_scheduler

Overview:
- Sits between the sprite draw queue (dequeue/is_empty/head fields) and two renderer lanes, one per sprite storage read port (r0, r1).
- Per frame, pops queued draw commands, validates them and hands each to a free lane round-robin.
- At the frame deadline, stops dispatching and waits for both lanes to go idle, then signals frame completion.

Parameters:
- SPRITE_NUM, 32, number of sprites in storage. Ids at or above this are invalid. SEL_W = $clog2(SPRITE_NUM), derived locally.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse opening a frame window
- frame_end  in  1  one-cycle pulse: frame deadline reached
- q_is_empty  in  1  draw queue empty
- q_sprite_id  in  8  queue head id
- q_sprite_x  in  16  queue head x
- q_sprite_y  in  16  queue head y
- q_sprite_scale  in  8  queue head scale
- q_dequeue  out  1  one-cycle pop strobe to the queue
- lane_valid  out  2  per-lane command valid
- lane_ready  in  2  per-lane accept
- lane_idle  in  2  renderer lane finished all accepted work
- lane_select  out  2*SEL_W  lane i payload at [i*SEL_W +: SEL_W]
- lane_x  out  32  lane i at [i*16 +: 16]
- lane_y  out  32  lane i at [i*16 +: 16]
- lane_scale  out  16  lane i at [i*8 +: 8]
- frame_done  out  1  one-cycle completion pulse
- frame_overrun  out  1  queue still non-empty at frame_end; held until next accepted frame_start
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer rr = 0. Lane payload registers are cleared to 0.
- Head validity:
  - The head is valid when q_is_empty == 0. Fields are sampled combinationally in RUN.
  - After any q_dequeue pulse the scheduler spends one cycle in SETTLE before sampling the head again. Maximum rate is one pop per 2 cycles.
- Lane free: lane_valid[i] == 0.
- Lane handshake:
  - When lane_valid[i] && lane_ready[i] at a posedge, lane_valid[i] clears on that edge.
  - Payload is stable while valid is high.
- States:
  - IDLE:
    - frame_start moves to RUN and clears frame_overrun.
    - frame_end is ignored.
  - RUN, priority order:
    - (1) frame_end: go to FLUSH and set frame_overrun = !q_is_empty. No pop this cycle.
    - (2) Head valid and invalid (id >= SPRITE_NUM, or scale == 0): pulse q_dequeue, no dispatch, go to SETTLE.
    - (3) Head valid, valid entry, and at least one lane free:
      - Chosen lane = rr if free, otherwise the other lane.
      - Load the payload (select = id[SEL_W-1:0]), set lane_valid, pulse q_dequeue, set rr = chosen^1, go to SETTLE.
    - (4) Otherwise stay in RUN.
  - SETTLE: next cycle go to RUN. If frame_end arrives in this cycle, go to FLUSH with the same overrun rule.
  - FLUSH:
    - No pops.
    - When lane_valid == 2'b00 and lane_idle == 2'b11, pulse frame_done for 1 cycle and go to IDLE.
    - frame_end and frame_start are ignored.
- frame_start outside IDLE is ignored. In IDLE, simultaneous frame_start and frame_end: the start is taken, the end is ignored.
- Entries not popped at frame_end stay in the queue for the next frame.
- Reset assertion at any time (async) returns to reset values immediately. A pending lane_valid is dropped.

Optional Feature:
- Macro SPRITE_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_dispatched[15:0] and stat_dropped[15:0].
  - Both are cleared on reset and on each accepted frame_start.
  - stat_dispatched increments per lane load. stat_dropped increments per invalid pop.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then frame_start with 3 valid entries (ids 1, 2, 3), lanes always ready and idle:
  - q_dequeue pulses at cycles 1, 3, 5 after RUN entry.
  - Ids go to lanes 0, 1, 0.
  - frame_end followed by lane_idle = 11 gives frame_done 1 cycle after entering FLUSH, with frame_overrun = 0.
- Head id 40 (>= 32), then id 5 with scale 0, then id 6 scale 2:
  - Two pops with no lane_valid, then lane 0 gets select 6.
  - Stats (if enabled): dispatched 1, dropped 2.
- lane_ready held 0 on both lanes, 4 entries queued:
  - Exactly 2 pops, both lanes valid with stable payload.
  - No further q_dequeue until lane_ready[1] = 1, then the next entry goes to lane 1.
- frame_end in the same cycle as a poppable head in RUN:
  - No q_dequeue, state FLUSH, frame_overrun = 1.
  - Entry remains; the next frame_start clears overrun and pops it.
- reset_n low mid-FLUSH with lane_valid = 01:
  - All outputs 0 asynchronously, state IDLE.
  - frame_start afterwards operates normally with rr = 0.
- frame_start while in RUN: ignored. frame_done never pulses outside FLUSH.
